sd_byte_fifo: RTL

- Byte-wide circular FIFO placed directly downstream of the SD card SPI reader.
- Accepts the reader's fifo_data_in/fifo_push byte stream and buffers it.
- Downstream consumers (display/UART stages) drain it with a pop strobe.
- Tracks 512-byte SD block boundaries on the write side and flags overflow/underflow so that lost data is detectable.

---
 rtl/sd_byte_fifo.sv | 95 +++++++++
 1 files changed

// File: rtl/sd_byte_fifo.sv
// Byte-wide circular FIFO buffering the SD SPI reader stream for downstream consumers.
// Tracks 512-byte SD block boundaries on the write side and flags lost data via sticky errors.
module sd_byte_fifo #(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 10,
  parameter int BLOCK_BYTES = 512
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  push,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  out_valid,
  output logic                  empty,
  output logic                  full,
  output logic [ADDR_WIDTH:0]   count,
  output logic [ADDR_WIDTH-1:0] front,
  output logic [ADDR_WIDTH-1:0] rear,
  output logic                  block_ready,
  output logic                  block_pushed,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int BLK_W = (BLOCK_BYTES > 1) ? $clog2(BLOCK_BYTES) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] BLOCK_CNT = (ADDR_WIDTH + 1)'(BLOCK_BYTES);
  localparam logic [BLK_W-1:0]    BLK_LAST  = BLK_W'(BLOCK_BYTES - 1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [BLK_W-1:0]      blk_cnt;
  logic                  push_ok;
  logic                  pop_ok;

  assign empty       = (count == '0);
  assign full        = (count == DEPTH_CNT);
  assign block_ready = (count >= BLOCK_CNT);

  // A push into an empty FIFO is not readable in the same cycle, so pop is
  // judged on the pre-edge count alone; a push while full rides on the pop.
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  // Storage: one write port, no reset so it maps onto block RAM
  always_ff @(posedge clock) begin
    if (push_ok && !reset) begin
      mem[rear] <= data_in;
    end
  end

  // Registered read port and control state
  always_ff @(posedge clock) begin
    if (reset) begin
      front        <= '0;
      rear         <= '0;
      count        <= '0;
      data_out     <= '0;
      out_valid    <= 1'b0;
      block_pushed <= 1'b0;
      blk_cnt      <= '0;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      out_valid    <= pop_ok;
      block_pushed <= 1'b0;

      if (pop_ok) begin
        data_out <= mem[front];
        front    <= front + 1'b1;
      end

      if (push_ok) begin
        rear <= rear + 1'b1;
        if (blk_cnt == BLK_LAST) begin
          blk_cnt      <= '0;
          block_pushed <= 1'b1;
        end else begin
          blk_cnt <= blk_cnt + 1'b1;
        end
      end

      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      if (push && !push_ok) overflow  <= 1'b1;
      if (pop && !pop_ok)   underflow <= 1'b1;
    end
  end

endmodule
